// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command bytes for the character LCD refresh path.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  typedef enum logic [2:0] {
    S_POR_WAIT,
    S_INIT,
    S_L1_ADDR,
    S_L1_CHAR,
    S_L2_ADDR,
    S_L2_CHAR
  } top_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_SETUP,
    P_EN_HI,
    P_EN_LO,
    P_EXEC
  } bus_phase_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    init_cmd = CMD_FUNC_SET;
      2'd1:    init_cmd = CMD_DISP_ON;
      2'd2:    init_cmd = CMD_ENTRY;
      default: init_cmd = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD write: SETUP, E high for E_HIGH_CYC, EN_LO, then the execution wait.
// done marks the last wait cycle; a start in that cycle chains straight into the next SETUP.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int E_HIGH_CYC = 25,
  parameter int EXEC_CYC   = 2_500,
  parameter int CLEAR_CYC  = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] wr_byte,
  input  logic       long_wait,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  bus_phase_t  phase, phase_nxt;
  logic [19:0] cnt;
  logic [19:0] exec_last;
  logic        cnt_clr;
  logic        long_q;
  logic        load;

  assign exec_last = long_q ? 20'(CLEAR_CYC - 1) : 20'(EXEC_CYC - 1);
  assign done      = (phase == P_EXEC) && (cnt == exec_last);
  assign load      = start && ((phase == P_IDLE) || done);

  always_comb begin
    phase_nxt = phase;
    cnt_clr   = 1'b0;
    case (phase)
      P_IDLE:  if (load) phase_nxt = P_SETUP;
      P_SETUP: begin
        phase_nxt = P_EN_HI;
        cnt_clr   = 1'b1;
      end
      P_EN_HI: if (cnt == 20'(E_HIGH_CYC - 1)) phase_nxt = P_EN_LO;
      P_EN_LO: begin
        phase_nxt = P_EXEC;
        cnt_clr   = 1'b1;
      end
      P_EXEC:  if (done) phase_nxt = load ? P_SETUP : P_IDLE;
      default: phase_nxt = P_IDLE;
    endcase
  end

  // Bus byte and RS are captured only on the edge that enters SETUP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase    <= P_IDLE;
      cnt      <= 20'd0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      long_q   <= 1'b0;
    end else begin
      phase <= phase_nxt;
      lcd_e <= (phase_nxt == P_EN_HI);
      if (cnt_clr)              cnt <= 20'd0;
      else if (cnt != 20'hFFFFF) cnt <= cnt + 20'd1;
      if (load) begin
        lcd_rs   <= rs;
        lcd_data <= wr_byte;
        long_q   <= long_wait;
      end
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// 16x2 LCD refresher: power-on wait, init commands, then endless scan of slots 0..31.
// Each data slot costs CHAR_LAT fetch cycles plus one bus write; no backpressure from the source.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int POR_CYC    = 1_000_000,
  parameter int E_HIGH_CYC = 25,
  parameter int EXEC_CYC   = 2_500,
  parameter int CLEAR_CYC  = 100_000,
  parameter int CHAR_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       frame_done
);

  top_state_t  state, state_nxt;
  logic [2:0]  step, step_nxt;
  logic        fetching, fetching_nxt;
  logic [19:0] cnt;
  logic        cnt_clr;
  logic [4:0]  index_nxt;
  logic        fd_nxt;
  logic        bus_start;
  logic        bus_rs;
  logic [7:0]  bus_byte;
  logic        bus_long;
  logic        bus_done;

  assign lcd_rw   = 1'b0;
  assign bus_long = !bus_rs && (bus_byte == CMD_CLEAR);

  always_comb begin
    state_nxt    = state;
    step_nxt     = step;
    fetching_nxt = fetching;
    index_nxt    = index;
    fd_nxt       = 1'b0;
    cnt_clr      = 1'b0;
    bus_start    = 1'b0;
    bus_rs       = 1'b0;
    bus_byte     = 8'h00;
    case (state)
      S_POR_WAIT: begin
        if (cnt == 20'(POR_CYC - 1)) begin
          state_nxt = S_INIT;
          cnt_clr   = 1'b1;
        end
      end
      S_INIT: begin
        // Bus is idle on entry, so step 0 issues without waiting for done.
        if (step == 3'd0 || bus_done) begin
          bus_start = 1'b1;
          if (step == 3'd4) begin
            bus_byte  = CMD_LINE1;
            state_nxt = S_L1_ADDR;
          end else begin
            bus_byte = init_cmd(step[1:0]);
            step_nxt = step + 3'd1;
          end
        end
      end
      S_L1_ADDR, S_L2_ADDR: begin
        if (bus_done) begin
          state_nxt    = (state == S_L1_ADDR) ? S_L1_CHAR : S_L2_CHAR;
          fetching_nxt = 1'b1;
          cnt_clr      = 1'b1;
          if (state == S_L2_ADDR) index_nxt = index + 5'd1;
        end
      end
      S_L1_CHAR, S_L2_CHAR: begin
        if (fetching) begin
          if (cnt == 20'(CHAR_LAT - 1)) begin
            bus_start    = 1'b1;
            bus_rs       = 1'b1;
            bus_byte     = char_in;
            fetching_nxt = 1'b0;
          end
        end else if (bus_done) begin
          if (state == S_L1_CHAR && index == 5'd15) begin
            bus_start = 1'b1;
            bus_byte  = CMD_LINE2;
            state_nxt = S_L2_ADDR;
          end else if (state == S_L2_CHAR && index == 5'd31) begin
            bus_start = 1'b1;
            bus_byte  = CMD_LINE1;
            state_nxt = S_L1_ADDR;
            index_nxt = 5'd0;
            fd_nxt    = 1'b1;
          end else begin
            fetching_nxt = 1'b1;
            cnt_clr      = 1'b1;
            index_nxt    = index + 5'd1;
          end
        end
      end
      default: state_nxt = S_POR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_POR_WAIT;
      step       <= 3'd0;
      fetching   <= 1'b0;
      cnt        <= 20'd0;
      index      <= 5'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      step       <= step_nxt;
      fetching   <= fetching_nxt;
      index      <= index_nxt;
      frame_done <= fd_nxt;
      if (cnt_clr)               cnt <= 20'd0;
      else if (cnt != 20'hFFFFF) cnt <= cnt + 20'd1;
    end
  end

  lcd_bus_cycle #(
    .E_HIGH_CYC (E_HIGH_CYC),
    .EXEC_CYC   (EXEC_CYC),
    .CLEAR_CYC  (CLEAR_CYC)
  ) u_bus (
    .clk       (clk),
    .rst       (rst),
    .start     (bus_start),
    .rs        (bus_rs),
    .wr_byte   (bus_byte),
    .long_wait (bus_long),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .done      (bus_done)
  );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Bench for lcd_refresh_ctrl: expected writes queued by stimulus, checked at each lcd_e fall.
module tb_lcd_refresh_ctrl;

  localparam int POR = 10;
  localparam int EH  = 3;
  localparam int EX  = 5;
  localparam int CL  = 12;
  localparam int LAT = 2;
  localparam int FRAME_CYC = 32 * (LAT + 1 + EH + 1 + EX) + 2 * (1 + EH + 1 + EX);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] char_in;
  logic [4:0] index;
  logic       lcd_e, lcd_rs, lcd_rw, frame_done;
  logic [7:0] lcd_data;

  lcd_refresh_ctrl #(
    .POR_CYC(POR), .E_HIGH_CYC(EH), .EXEC_CYC(EX), .CLEAR_CYC(CL), .CHAR_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .index(index), .lcd_e(lcd_e),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Upstream source: one register after index; garbage toggles while E is high.
  logic [7:0] src_q = 8'h00;
  logic       tgl = 1'b0;
  always @(posedge clk) begin
    src_q <= 8'h40 + {3'b000, index};
    tgl   <= ~tgl;
  end
  assign char_in = lcd_e ? (tgl ? 8'hAA : 8'h55) : src_q;

  typedef struct {
    logic       rs;
    logic [7:0] dat;
    int         idx;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   frames = 0;
  int   cyc = 0;
  bit   last_long = 1'b0;
  bit   first_push = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic push_wr(input logic rs, input logic [7:0] d, input int idx);
    exp_t e;
    e.rs  = rs;
    e.dat = d;
    e.idx = idx;
    e.gap = first_push ? -1 : ((last_long ? CL : EX) + 2 + (rs ? LAT : 0));
    last_long  = !rs && (d == 8'h01);
    first_push = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    first_push = 1'b1;
    push_wr(1'b0, 8'h38, -1);
    push_wr(1'b0, 8'h0C, -1);
    push_wr(1'b0, 8'h06, -1);
    push_wr(1'b0, 8'h01, -1);
  endtask

  task automatic push_frame();
    push_wr(1'b0, 8'h80, -1);
    for (int i = 0; i < 16; i++) push_wr(1'b1, 8'(8'h40 + i), i);
    push_wr(1'b0, 8'hC0, -1);
    for (int i = 16; i < 32; i++) push_wr(1'b1, 8'(8'h40 + i), i);
  endtask

  // Monitor
  bit         pe, pfd, first_rise;
  int         hi_cnt, last_fall, rel_cnt;
  int         last_fd = -1;
  logic [7:0] pdat, hi_dat;
  exp_t       cur;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        pe = 1'b0; pfd = 1'b0; first_rise = 1'b1;
        rel_cnt = 0; hi_cnt = 0; pdat = lcd_data;
      end else begin
        rel_cnt++;
        if (lcd_e && !pe) begin
          chk("setup_data_hold", 32'(lcd_data), 32'(pdat));
          hi_dat = lcd_data;
          hi_cnt = 0;
          if (first_rise)
            chk("por_quiet", 32'(rel_cnt > POR), 32'd1);
          else if (exp_q.size() > 0 && exp_q[0].gap >= 0)
            chk("gap_fall_to_rise", 32'(cyc - last_fall), 32'(exp_q[0].gap));
          first_rise = 1'b0;
        end
        if (lcd_e) begin
          hi_cnt++;
          chk("en_hi_data_stable", 32'(lcd_data), 32'(hi_dat));
        end
        if (!lcd_e && pe) begin
          chk("en_lo_data_hold", 32'(lcd_data), 32'(hi_dat));
          chk("e_high_width", 32'(hi_cnt), 32'(EH));
          chk("lcd_rw", 32'(lcd_rw), 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got rs=%0d data=0x%0h, required no write", lcd_rs, lcd_data);
          end else begin
            cur = exp_q.pop_front();
            chk("write_rs", 32'(lcd_rs), 32'(cur.rs));
            chk("write_data", 32'(lcd_data), 32'(cur.dat));
            if (cur.idx >= 0) chk("write_index", 32'(index), 32'(cur.idx));
          end
          last_fall = cyc;
        end
        if (frame_done) begin
          frames++;
          chk("fd_index", 32'(index), 32'd0);
          chk("fd_line1_setup", 32'(lcd_data), 32'h80);
          chk("fd_rs", 32'(lcd_rs), 32'd0);
          chk("fd_e_low", 32'(lcd_e), 32'd0);
          if (last_fd >= 0) chk("frame_period", 32'(cyc - last_fd), 32'(FRAME_CYC));
          last_fd = cyc;
        end
        if (pfd) chk("fd_one_cycle", 32'(frame_done), 32'd0);
        pe   = lcd_e;
        pfd  = frame_done;
        pdat = lcd_data;
      end
    end
  end

  // Stimulus
  bit ok;
  initial begin
    rst = 1'b0;
    #23;
    chk("rst_lcd_e", 32'(lcd_e), 32'd0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
    chk("rst_lcd_data", 32'(lcd_data), 32'h00);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    push_init();
    for (int f = 0; f < 4; f++) push_frame();
    @(posedge clk);
    #2 rst = 1'b1;

    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (frames == 3 && index == 5'd20 && lcd_e) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_frame4_slot20", 32'(ok), 32'd1);
    chk("frames_before_reset", 32'(frames), 32'd3);

    #2 rst = 1'b0;
    #1;
    chk("arst_lcd_e", 32'(lcd_e), 32'd0);
    chk("arst_lcd_data", 32'(lcd_data), 32'h00);
    chk("arst_index", 32'(index), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);

    exp_q.delete();
    push_init();
    push_wr(1'b0, 8'h80, -1);
    for (int i = 0; i < 3; i++) push_wr(1'b1, 8'(8'h40 + i), i);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("post_reset_sequence_done", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
